// File: rtl/alu_bist_pkg.sv
// Shared types, ALU select encodings, LFSR taps and the golden ALU model for the BIST controller.
package alu_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_NEXT,
        ST_FIN
    } state_t;

    localparam logic [2:0] OP_TFR = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_AND = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Returns {co, f}; co is only meaningful for the arithmetic ops
    function automatic logic [32:0] golden(input logic [2:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        ci);
        logic [32:0] r;
        r = '0;
        case (op)
            OP_TFR:  r = {1'b0, a} + {32'b0, ci};
            OP_ADD:  r = {1'b0, a} + {1'b0, b} + {32'b0, ci};
            OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + {32'b0, ci};
            OP_DEC:  r = {1'b0, a} + 33'h0FFFFFFFF + {32'b0, ci};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, ~a};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_bist_ctrl_lfsr.sv
// 32-bit Galois LFSR with synchronous seed reload and step enable; a zero seed is replaced by 1.
module bist_lfsr32
    import alu_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED_EFF;
        end else if (load) begin
            value <= SEED_EFF;
        end else if (step) begin
            value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_TAPS : 32'h0);
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST initiator for alu_32_bit: sweeps all select codes with LFSR operands and checks F/Co.
// Optional first-failure capture ports are enabled by defining ALU_BIST_CAPTURE_EN.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int          VECTORS_PER_OP = 16,
    parameter int          SETTLE_CYCLES  = 1,
    parameter logic [31:0] SEED_A         = 32'h81010101,
    parameter logic [31:0] SEED_B         = 32'h61616161
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        S0,
    output logic        S1,
    output logic        S2,
    output logic        Ci,
    input  logic [31:0] F,
    input  logic        Co,
    output logic        busy,
    output logic        done,
    output logic        pass,
`ifdef ALU_BIST_CAPTURE_EN
    output logic [31:0] fail_a,
    output logic [31:0] fail_b,
    output logic [2:0]  fail_op,
    output logic        fail_ci,
    output logic [31:0] fail_f,
    output logic        fail_co,
`endif
    output logic [15:0] err_cnt
);

    localparam logic [7:0] K_LAST    = 8'(VECTORS_PER_OP - 1);
    localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic [7:0]  k_reg;
    logic [3:0]  wait_reg;
    logic        arm_reg;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic        lfsr_load;
    logic        lfsr_step;
    logic        k_last;
    logic        start_ok;
    logic [32:0] expect_val;
    logic        mismatch;

    // arm_reg blocks a start that lands on the first edge after reset release
    assign start_ok  = start && arm_reg;
    assign k_last    = (k_reg == K_LAST);
    assign lfsr_load = ((state_reg == ST_IDLE) && start_ok) || ((state_reg == ST_NEXT) && k_last);
    assign lfsr_step = (state_reg == ST_NEXT) && !k_last;

    assign expect_val = golden({S2, S1, S0}, a, b, Ci);
    assign mismatch   = (F != expect_val[31:0]) || (!S2 && (Co != expect_val[32]));

    bist_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_a)
    );

    bist_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= 3'd0;
            k_reg     <= 8'd0;
            wait_reg  <= 4'd0;
            arm_reg   <= 1'b0;
            a         <= 32'h0;
            b         <= 32'h0;
            {S2, S1, S0} <= 3'b000;
            Ci        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 16'h0;
`ifdef ALU_BIST_CAPTURE_EN
            fail_a    <= 32'h0;
            fail_b    <= 32'h0;
            fail_op   <= 3'd0;
            fail_ci   <= 1'b0;
            fail_f    <= 32'h0;
            fail_co   <= 1'b0;
`endif
        end else begin
            arm_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        state_reg <= ST_DRIVE;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        op_reg    <= 3'd0;
                        k_reg     <= 8'd0;
                        err_cnt   <= 16'h0;
`ifdef ALU_BIST_CAPTURE_EN
                        fail_a    <= 32'h0;
                        fail_b    <= 32'h0;
                        fail_op   <= 3'd0;
                        fail_ci   <= 1'b0;
                        fail_f    <= 32'h0;
                        fail_co   <= 1'b0;
`endif
                    end
                end
                ST_DRIVE: begin
                    a            <= lfsr_a;
                    b            <= lfsr_b;
                    {S2, S1, S0} <= op_reg;
                    Ci           <= ~k_reg[0];
                    wait_reg     <= 4'd0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_reg == WAIT_LAST) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        wait_reg <= wait_reg + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != 16'hFFFF) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
`ifdef ALU_BIST_CAPTURE_EN
                        if (err_cnt == 16'h0) begin
                            fail_a  <= a;
                            fail_b  <= b;
                            fail_op <= {S2, S1, S0};
                            fail_ci <= Ci;
                            fail_f  <= F;
                            fail_co <= Co;
                        end
`endif
                    end
                    state_reg <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (k_last) begin
                        k_reg  <= 8'd0;
                        op_reg <= op_reg + 3'd1;
                        if (op_reg == OP_NOT) begin
                            state_reg <= ST_FIN;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            pass      <= (err_cnt == 16'h0);
                        end else begin
                            state_reg <= ST_DRIVE;
                        end
                    end else begin
                        k_reg     <= k_reg + 8'd1;
                        state_reg <= ST_DRIVE;
                    end
                end
                ST_FIN: begin
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench: behavioural ALU with fault injection, vector-list model and per-cycle compare.
module tb_alu_bist_ctrl;

    localparam int VP   = 16;
    localparam int NV   = 8 * VP;
    localparam int PER  = 4;
    localparam int TEND = NV * PER;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1, f0_fault;

    logic [31:0] a0, b0, F0, fr0;
    logic s00, s10, s20, ci0, co0, busy0, done0, pass0;
    logic [15:0] err0;
    logic [31:0] a1, b1, F1, fr1;
    logic s01, s11, s21, ci1, co1, co_raw1, busy1, done1, pass1;
    logic [15:0] err1;
`ifdef ALU_BIST_CAPTURE_EN
    logic [31:0] fa0, fb0, ff0, fa1, fb1, ff1;
    logic [2:0]  fop0, fop1;
    logic        fci0, fco0, fci1, fco1;
`endif

    function automatic logic [32:0] alu_ref(input logic [2:0] sel, input logic [31:0] x,
                                            input logic [31:0] y, input logic c);
        case (sel)
            3'd0:    return {1'b0, x} + 33'(c);
            3'd1:    return {1'b0, x} + {1'b0, y} + 33'(c);
            3'd2:    return {1'b0, x} + {1'b0, ~y} + 33'(c);
            3'd3:    return {1'b0, x} + 33'h0FFFFFFFF + 33'(c);
            3'd4:    return {1'b0, x | y};
            3'd5:    return {1'b0, x ^ y};
            3'd6:    return {1'b0, x & y};
            default: return {1'b0, ~x};
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    assign {co0, fr0} = alu_ref({s20, s10, s00}, a0, b0, ci0);
    assign F0 = {fr0[31:1], fr0[0] & ~f0_fault};
    assign {co_raw1, fr1} = alu_ref({s21, s11, s01}, a1, b1, ci1);
    assign F1  = fr1;
    assign co1 = 1'b0;

    alu_bist_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .S0(s00), .S1(s10), .S2(s20),
        .Ci(ci0), .F(F0), .Co(co0), .busy(busy0), .done(done0), .pass(pass0),
`ifdef ALU_BIST_CAPTURE_EN
        .fail_a(fa0), .fail_b(fb0), .fail_op(fop0), .fail_ci(fci0), .fail_f(ff0), .fail_co(fco0),
`endif
        .err_cnt(err0)
    );

    alu_bist_ctrl #(.VECTORS_PER_OP(1), .SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .S0(s01), .S1(s11), .S2(s21),
        .Ci(ci1), .F(F1), .Co(co1), .busy(busy1), .done(done1), .pass(pass1),
`ifdef ALU_BIST_CAPTURE_EN
        .fail_a(fa1), .fail_b(fb1), .fail_op(fop1), .fail_ci(fci1), .fail_f(ff1), .fail_co(fco1),
`endif
        .err_cnt(err1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected vector list for dut0, with error prefix counts for the active fault
    logic [31:0] ma [0:NV-1];
    logic [31:0] mb [0:NV-1];
    logic [2:0]  mop[0:NV-1];
    logic        mci[0:NV-1];
    int          mpre[0:NV];
    int          first_bad;

    task automatic build_model(input bit f0f);
        logic [31:0] xa, xb;
        logic [32:0] g;
        int v;
        mpre[0]   = 0;
        first_bad = -1;
        for (int op = 0; op < 8; op++) begin
            xa = 32'h81010101;
            xb = 32'h61616161;
            for (int k = 0; k < VP; k++) begin
                v = op * VP + k;
                ma[v]  = xa;
                mb[v]  = xb;
                mop[v] = 3'(op);
                mci[v] = (k % 2 == 0);
                g = alu_ref(3'(op), xa, xb, mci[v]);
                mpre[v+1] = mpre[v] + ((f0f && g[0]) ? 1 : 0);
                if (f0f && g[0] && first_bad < 0) first_bad = v;
                xa = lfsr_next(xa);
                xb = lfsr_next(xb);
            end
        end
    endtask

    bit mon_on  = 1'b0;
    bit run_done = 1'b0;
    int t_mon   = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            int v, p;
            t_mon++;
            v = (t_mon - 1) / PER;
            p = (t_mon - 1) % PER;
            check("busy", 32'(busy0), 32'(t_mon <= TEND));
            check("done", 32'(done0), 32'(t_mon == TEND + 1));
            if (t_mon <= TEND && p >= 1) begin
                check("a", a0, ma[v]);
                check("b", b0, mb[v]);
                check("sel", 32'({s20, s10, s00}), 32'(mop[v]));
                check("ci", 32'(ci0), 32'(mci[v]));
                check("err_run", 32'(err0), 32'(mpre[(p == 3) ? v + 1 : v]));
            end
            if (t_mon == 32 * PER + 3) begin
                check("probe_a", a0, 32'h81010101);
                check("probe_b", b0, 32'h61616161);
                check("probe_ci", 32'(ci0), 32'd1);
                check("probe_F", {fr0}, 32'h1F9F9FA0);
                check("probe_Co", 32'(co0), 32'd1);
            end
            if (t_mon == TEND + 1) begin
                check("pass_end", 32'(pass0), 32'(mpre[NV] == 0));
                check("err_end", 32'(err0), 32'(mpre[NV]));
                mon_on   = 1'b0;
                run_done = 1'b1;
            end
        end
    end

    task automatic run0(input int restart_at);
        @(negedge clk); #1;
        start0 = 1'b1; t_mon = 0; run_done = 1'b0; mon_on = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        for (int i = 0; i < 2000 && !run_done; i++) begin
            @(negedge clk); #1;
            start0 = (restart_at > 0 && t_mon == restart_at);
        end
        start0 = 1'b0;
        check("run_timeout", 32'(run_done), 32'd1);
        mon_on = 1'b0;
        $display("[TB] run dut0 finished: err_cnt=%0d pass=%0b", err0, pass0);
    endtask

    initial begin
        int dcnt, cyc;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; f0_fault = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a", a0, 32'h0);
        check("rst_b", b0, 32'h0);
        check("rst_sel", 32'({s20, s10, s00, ci0}), 32'h0);
        check("rst_flags", 32'({busy0, done0, pass0}), 32'h0);
        check("rst_err", 32'(err0), 32'h0);
        check("rst_busy1", 32'(busy1), 32'h0);
        rst = 1'b0; start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        check("start_at_release", 32'(busy0), 32'h0);
        $display("[TB] start at reset release: busy=%0b", busy0);

        build_model(1'b0);
        run0(2);

        f0_fault = 1'b1;
        build_model(1'b1);
        check("model_f0_errs_nonzero", 32'(mpre[NV] >= 1 && mpre[NV] <= NV), 32'd1);
        run0(0);
`ifdef ALU_BIST_CAPTURE_EN
        check("cap_f0", 32'(ff0[0]), 32'd0);
        check("cap_op", 32'(fop0), 32'(mop[first_bad]));
        check("cap_a", fa0, ma[first_bad]);
        check("cap_ci", 32'(fci0), 32'(mci[first_bad]));
`endif
        f0_fault = 1'b0;
        build_model(1'b0);

        // Abort a run with reset at cycle 200
        @(negedge clk); #1;
        start0 = 1'b1; t_mon = 0; run_done = 1'b0; mon_on = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        for (int i = 0; i < 400 && t_mon < 200; i++) @(negedge clk);
        mon_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_a", a0, 32'h0);
        check("abort_flags", 32'({busy0, done0, pass0}), 32'h0);
        check("abort_err", 32'(err0), 32'h0);
        dcnt = 0;
        repeat (4) begin @(negedge clk); dcnt += done0; end
        rst = 1'b0;
        repeat (600) begin @(negedge clk); dcnt += done0; end
        check("abort_no_done", 32'(dcnt), 32'd0);
        $display("[TB] reset abort at cycle 200: busy=%0b done_seen=%0d", busy0, dcnt);
        run0(0);

        // dut1: one vector per op, 3 settle cycles, Co stuck low
        @(negedge clk); #1;
        start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 200) begin @(negedge clk); #1; cyc++; end
        check("dut1_done_cycle", 32'(cyc), 32'd49);
        check("dut1_err", 32'(err1), 32'd2);
        check("dut1_pass", 32'(pass1), 32'd0);
        $display("[TB] run dut1 finished at cycle %0d: err_cnt=%0d pass=%0b", cyc, err1, pass1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
- Built-in self-test initiator for alu_32_bit; sits on the ALU's operand/select inputs and F/Co outputs.
- On a start pulse, sweeps all 8 select codes with pseudo-random operands, waits for the ALU to settle, compares F/Co against an internal golden model, and reports pass/fail, an error count and status.
- Complements the directed ALU benches with on-chip, self-checking stimulus.

Parameters:
- VECTORS_PER_OP, 16, vectors applied per select code (1..256).
- SETTLE_CYCLES, 1, clock cycles between driving operands and sampling F/Co (1..15).
- SEED_A, 32'h81010101, LFSR-A seed, reloaded at the start of each op; 0 is replaced by 1.
- SEED_B, 32'h61616161, LFSR-B seed, same rules as SEED_A.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; ignored unless in IDLE.
- a  out  32  ALU operand A.
- b  out  32  ALU operand B.
- S0  out  1  ALU select bit 0.
- S1  out  1  ALU select bit 1.
- S2  out  1  ALU select bit 2.
- Ci  out  1  ALU carry-in.
- F  in  32  ALU result.
- Co  in  1  ALU carry-out.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last CHECK.
- pass  out  1  valid from done until the next accepted start; 1 iff err_cnt==0.
- err_cnt  out  16  mismatching vectors in the run; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst=1): state IDLE; a=b=0, S2S1S0=000, Ci=0, busy=0, done=0, pass=0, err_cnt=0. Reset mid-run aborts immediately; no done pulse.
- FSM states: IDLE, DRIVE, WAIT, CHECK, NEXT, FIN.
- IDLE: start=1 -> DRIVE. Op index=0, vector index k=0, err_cnt cleared, LFSRs loaded with seeds.
- DRIVE (1 cycle): registers a=LFSR-A, b=LFSR-B, {S2,S1,S0}=op, Ci=~k[0]; first vector of every op has Ci=1. -> WAIT.
- WAIT: exactly SETTLE_CYCLES cycles, outputs held stable. -> CHECK.
- CHECK (1 cycle): compares F, and Co when S2=0, to the golden model. On mismatch, err_cnt increments, saturating. -> NEXT.
- NEXT (1 cycle): steps both LFSRs and k.
  - If k was VECTORS_PER_OP-1: k=0, op increments, LFSRs reload seeds.
  - If op was 7: -> FIN. Otherwise -> DRIVE.
- FIN: done=1 for one cycle, busy=0, pass updated. -> IDLE. Outputs a/b/S/Ci hold their last values.
- Run length: start accepted at cycle 0 -> done at cycle 8*VECTORS_PER_OP*(SETTLE_CYCLES+3)+1.
- Golden model (33-bit sum, Co=bit 32):
  - 000 F=a+Ci
  - 001 F=a+b+Ci
  - 010 F=a+~b+Ci (Ci=1 gives a-b)
  - 011 F=a+32'hFFFFFFFF+Ci
  - 100 F=a|b
  - 101 F=a^b
  - 110 F=a&b
  - 111 F=~a
  - For logic ops Co is not checked.
- LFSRs: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, one step per NEXT.
- start during non-IDLE states is ignored. start coinciding with reset deassertion is ignored.

Optional Feature:
- Macro ALU_BIST_CAPTURE_EN.
- Defined: adds outputs fail_a[31:0], fail_b[31:0], fail_op[2:0], fail_ci, fail_f[31:0], fail_co.
  - Loaded on the first mismatch of a run; held until the next accepted start or reset.
  - Reset and start clear them to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package alu_bist_pkg holds:
  - state enum;
  - op encodings OP_TFR, OP_ADD, OP_SUB, OP_DEC, OP_OR, OP_XOR, OP_AND, OP_NOT;
  - LFSR tap constant 32'h80200003;
  - function golden(op,a,b,ci) returning {co,f}.
- One sub-module: bist_lfsr32 (seed load, step enable), instantiated twice.

Test Plan:
- Correct alu_32_bit, defaults, start at cycle 0 -> done at cycle 513 (8*16*4+1), pass=1, err_cnt=0, busy high cycles 1..512.
- Probe first op-010 DRIVE with default seeds -> a=32'h81010101, b=32'h61616161, Ci=1; CHECK sees F=32'h1F9F9FA0, Co=1, no error.
- ALU wrapper with F[0] forced to 0 -> pass=0, err_cnt in 1..128; with ALU_BIST_CAPTURE_EN, fail_f[0]=0 and fail_op equals the first failing op.
- start pulsed again during WAIT -> ignored; single done at the nominal cycle; err_cnt unaffected.
- rst asserted mid-run (cycle 200) -> outputs go to reset values asynchronously, no done. New start after release -> full clean run, pass=1.
- SETTLE_CYCLES=3, VECTORS_PER_OP=1, ALU with Co stuck at 0 -> done at cycle 49. Errors only in ops whose golden Co=1 for vector 0; the logic ops never count Co.
